// File: rtl/mandel_scan_ctrl_if.sv
// Core-facing and result-stream signals of the Mandelbrot frame scheduler.
// The master modport is the scheduler. The slave modport is the core plus the
// result sink.
interface mandel_scan_ctrl_if #(
  parameter int W      = 16,
  parameter int DIM_W  = 8,
  parameter int ITER_W = 7
);
  // Iteration core side
  logic              o_core_start;
  logic [W-1:0]      o_core_cr;
  logic [W-1:0]      o_core_ci;
  logic              i_core_done;
  logic              i_core_unbounded;
  logic [ITER_W-1:0] i_core_iter;

  // Result stream toward readout
  logic              o_res_valid;
  logic              i_res_ready;
  logic [DIM_W-1:0]  o_res_x;
  logic [DIM_W-1:0]  o_res_y;
  logic [ITER_W-1:0] o_res_iter;
  logic              o_res_unbounded;

  modport master (
    output o_core_start, o_core_cr, o_core_ci,
    input  i_core_done, i_core_unbounded, i_core_iter,
    output o_res_valid, o_res_x, o_res_y, o_res_iter, o_res_unbounded,
    input  i_res_ready
  );

  modport slave (
    input  o_core_start, o_core_cr, o_core_ci,
    output i_core_done, i_core_unbounded, i_core_iter,
    input  o_res_valid, o_res_x, o_res_y, o_res_iter, o_res_unbounded,
    output i_res_ready
  );
endinterface

// File: rtl/mandel_scan_ctrl.sv
// Frame scheduler for the Mandelbrot iteration core. It walks a cols x rows
// grid in raster order. For each pixel it steps the C coordinate, starts the
// core, waits for the result and hands it out on a valid/ready stream.
module mandel_scan_ctrl #(
  parameter int W      = 16,
  parameter int DIM_W  = 8,
  parameter int ITER_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [W-1:0]     i_cr0,
  input  logic [W-1:0]     i_ci0,
  input  logic [W-1:0]     i_cr_step,
  input  logic [W-1:0]     i_ci_step,
  input  logic [DIM_W-1:0] i_cols,
  input  logic [DIM_W-1:0] i_rows,
  mandel_scan_ctrl_if.master bus,
  output logic             o_busy,
  output logic             o_frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t state, state_next;

  // Frame configuration, held for the whole frame
  logic [W-1:0]     cr0_q, cr_step_q, ci_step_q;
  logic [DIM_W-1:0] cols_q, rows_q;

  // Scan position and current coordinate
  logic [DIM_W-1:0] x_q, y_q;
  logic [W-1:0]     cr_q, ci_q;

  // Result holding registers
  logic              res_valid_q;
  logic [DIM_W-1:0]  res_x_q, res_y_q;
  logic [ITER_W-1:0] res_iter_q;
  logic              res_unb_q;
  logic              frame_done_q;

  // Control strobes from the FSM to the datapath
  logic load_cfg, capture, step_col, step_row, frame_done_set;

  logic zero_size, last_col, last_row, handshake;

  assign zero_size = (i_cols == '0) || (i_rows == '0);
  assign last_col  = (x_q == cols_q - DIM_W'(1));
  assign last_row  = (y_q == rows_q - DIM_W'(1));
  assign handshake = res_valid_q && bus.i_res_ready;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the
    // evaluation order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and control-strobe decode; abort overrides done and handshake
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_next     = state;
    load_cfg       = 1'b0;
    capture        = 1'b0;
    step_col       = 1'b0;
    step_row       = 1'b0;
    frame_done_set = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          if (zero_size) begin
            frame_done_set = 1'b1;
          end else begin
            load_cfg   = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_next = i_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (i_abort) begin
          state_next = S_IDLE;
        end else if (bus.i_core_done) begin
          capture    = 1'b1;
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (i_abort) begin
          state_next = S_IDLE;
        end else if (handshake) begin
          if (last_col && last_row) begin
            frame_done_set = 1'b1;
            state_next     = S_IDLE;
          end else if (last_col) begin
            step_row   = 1'b1;
            state_next = S_ISSUE;
          end else begin
            step_col   = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: config capture, coordinate stepping, and the result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cr0_q        <= '0;
      cr_step_q    <= '0;
      ci_step_q    <= '0;
      cols_q       <= '0;
      rows_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      res_valid_q  <= 1'b0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      res_iter_q   <= '0;
      res_unb_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_set;
      // Valid is high exactly while the FSM sits in EMIT.
      res_valid_q  <= (state_next == S_EMIT);

      if (load_cfg) begin
        cr0_q     <= i_cr0;
        cr_step_q <= i_cr_step;
        ci_step_q <= i_ci_step;
        cols_q    <= i_cols;
        rows_q    <= i_rows;
        x_q       <= '0;
        y_q       <= '0;
        cr_q      <= i_cr0;
        ci_q      <= i_ci0;
      end

      if (capture) begin
        res_x_q    <= x_q;
        res_y_q    <= y_q;
        res_iter_q <= bus.i_core_iter;
        res_unb_q  <= bus.i_core_unbounded;
      end

      // Coordinates wrap modulo 2^W; no saturation is intended.
      if (step_col) begin
        x_q  <= x_q + DIM_W'(1);
        cr_q <= cr_q + cr_step_q;
      end

      if (step_row) begin
        x_q  <= '0;
        cr_q <= cr0_q;
        y_q  <= y_q + DIM_W'(1);
        ci_q <= ci_q + ci_step_q;
      end
    end
  end

  assign bus.o_core_start    = (state == S_ISSUE);
  assign bus.o_core_cr       = cr_q;
  assign bus.o_core_ci       = ci_q;
  assign bus.o_res_valid     = res_valid_q;
  assign bus.o_res_x         = res_x_q;
  assign bus.o_res_y         = res_y_q;
  assign bus.o_res_iter      = res_iter_q;
  assign bus.o_res_unbounded = res_unb_q;
  assign o_busy              = (state != S_IDLE);
  assign o_frame_done        = frame_done_q;

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Directed bench for mandel_scan_ctrl. A behavioural core model answers each
// core start after core_lat cycles. It returns iter = global start index and
// unbounded = index bit 0. A monitor logs core starts, result handshakes and
// frame_done pulses.
module tb_mandel_scan_ctrl;
  localparam int W      = 16;
  localparam int DIM_W  = 8;
  localparam int ITER_W = 7;
  localparam int LOG_N  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_abort;
  logic [W-1:0]     cr0, ci0, cr_step, ci_step;
  logic [DIM_W-1:0] cols, rows;
  logic             busy, frame_done;

  mandel_scan_ctrl_if #(.W(W), .DIM_W(DIM_W), .ITER_W(ITER_W)) bus ();

  mandel_scan_ctrl #(.W(W), .DIM_W(DIM_W), .ITER_W(ITER_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_cr0       (cr0),
    .i_ci0       (ci0),
    .i_cr_step   (cr_step),
    .i_ci_step   (ci_step),
    .i_cols      (cols),
    .i_rows      (rows),
    .bus         (bus),
    .o_busy      (busy),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Core model and monitor state (written only by the block below)
  int                core_lat = 3;
  int                n_starts = 0;
  int                n_results = 0;
  int                n_fd = 0;
  logic [W-1:0]      cr_log [LOG_N];
  logic [W-1:0]      ci_log [LOG_N];
  logic [DIM_W-1:0]  rx_log [LOG_N];
  logic [DIM_W-1:0]  ry_log [LOG_N];
  logic [ITER_W-1:0] riter_log [LOG_N];
  logic              runb_log [LOG_N];
  bit                pend = 1'b0;
  int                pend_cnt = 0;
  logic [ITER_W-1:0] pend_iter;
  logic              pend_unb;

  // Core model and monitor, both working on the falling edge
  initial begin
    bus.i_core_done      = 1'b0;
    bus.i_core_iter      = '0;
    bus.i_core_unbounded = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_core_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            bus.i_core_done      = 1'b1;
            bus.i_core_iter      = pend_iter;
            bus.i_core_unbounded = pend_unb;
            pend = 1'b0;
          end
        end
        if (bus.o_core_start) begin
          if (n_starts < LOG_N) begin
            cr_log[n_starts] = bus.o_core_cr;
            ci_log[n_starts] = bus.o_core_ci;
          end
          pend_iter = ITER_W'(n_starts);
          pend_unb  = n_starts[0];
          pend      = 1'b1;
          pend_cnt  = core_lat;
          n_starts++;
        end
        if (bus.o_res_valid && bus.i_res_ready) begin
          if (n_results < LOG_N) begin
            rx_log[n_results]    = bus.o_res_x;
            ry_log[n_results]    = bus.o_res_y;
            riter_log[n_results] = bus.o_res_iter;
            runb_log[n_results]  = bus.o_res_unbounded;
          end
          n_results++;
        end
        if (frame_done) n_fd++;
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [W-1:0] c0, input logic [W-1:0] i0,
                             input logic [W-1:0] cs, input logic [W-1:0] is,
                             input logic [DIM_W-1:0] nc, input logic [DIM_W-1:0] nr);
    cr0 = c0; ci0 = i0; cr_step = cs; ci_step = is; cols = nc; rows = nr;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!bus.o_res_valid && n < budget) begin tick(); n++; end
    checks++;
    if (bus.o_res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: no result within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, frame_done, bus.o_core_start, bus.o_res_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/fd/start/valid=%b required 0000",
               {busy, frame_done, bus.o_core_start, bus.o_res_valid});
    end
    checks++;
    if ({bus.o_core_cr, bus.o_core_ci, bus.o_res_x, bus.o_res_y, bus.o_res_iter,
         bus.o_res_unbounded} !== '0) begin
      errors++;
      $display("FAIL reset_data: cr=%h ci=%h x=%0d y=%0d iter=%0d unb=%0b required all 0",
               bus.o_core_cr, bus.o_core_ci, bus.o_res_x, bus.o_res_y, bus.o_res_iter,
               bus.o_res_unbounded);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame_2x2();
    int bs = n_starts, br = n_results, bf = n_fd;
    core_lat = 3;
    bus.i_res_ready = 1'b1;
    start_frame(16'h1000, 16'hF000, 16'h0100, 16'h0200, 8'd2, 8'd2);
    checks++;
    if (bus.o_core_start !== 1'b1) begin
      errors++;
      $display("FAIL 2x2_start_latency: core_start=%0b required 1", bus.o_core_start);
    end
    wait_idle(200, "2x2_idle");
    tick(); tick();
    checks++;
    if (n_starts - bs != 4 || n_results - br != 4 || n_fd - bf != 1) begin
      errors++;
      $display("FAIL 2x2_counts: starts=%0d results=%0d frame_done=%0d required 4 4 1",
               n_starts - bs, n_results - br, n_fd - bf);
    end
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0]      ecr, eci;
      logic [ITER_W-1:0] eit;
      int                x = i % 2;
      int                y = i / 2;
      int                g = bs + i;
      ecr = W'(32'h1000 + x * 32'h0100);
      eci = W'(32'hF000 + y * 32'h0200);
      eit = ITER_W'(g);
      checks++;
      if (cr_log[bs+i] !== ecr || ci_log[bs+i] !== eci) begin
        errors++;
        $display("FAIL 2x2_coord[%0d]: got (%h,%h) required (%h,%h)",
                 i, cr_log[bs+i], ci_log[bs+i], ecr, eci);
      end
      checks++;
      if (rx_log[br+i] !== DIM_W'(x) || ry_log[br+i] !== DIM_W'(y) ||
          riter_log[br+i] !== eit || runb_log[br+i] !== g[0]) begin
        errors++;
        $display("FAIL 2x2_result[%0d]: got x=%0d y=%0d iter=%0d unb=%0b required %0d %0d %0d %0b",
                 i, rx_log[br+i], ry_log[br+i], riter_log[br+i], runb_log[br+i], x, y, eit, g[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bs = n_starts, br = n_results;
    logic [ITER_W-1:0] eit;
    core_lat = 2;
    bus.i_res_ready = 1'b0;
    eit = ITER_W'(bs + 1);
    start_frame(16'h0000, 16'h0000, 16'h0010, 16'h0020, 8'd2, 8'd2);
    for (int r = 0; r < 4; r++) begin
      wait_valid(50, "bp_valid");
      if (r == 1) begin
        for (int h = 0; h < 5; h++) begin
          checks++;
          if (bus.o_res_valid !== 1'b1 || bus.o_res_x !== 8'd1 || bus.o_res_y !== 8'd0 ||
              bus.o_res_iter !== eit || bus.o_res_unbounded !== eit[0] ||
              bus.o_core_start !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: v=%0b x=%0d y=%0d iter=%0d unb=%0b start=%0b required 1 1 0 %0d %0b 0",
                     h, bus.o_res_valid, bus.o_res_x, bus.o_res_y, bus.o_res_iter,
                     bus.o_res_unbounded, bus.o_core_start, eit, eit[0]);
          end
          tick();
        end
      end
      bus.i_res_ready = 1'b1;
      tick();
      bus.i_res_ready = 1'b0;
      checks++;
      if (r < 3) begin
        if (bus.o_core_start !== 1'b1 || bus.o_res_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_restart[%0d]: start=%0b valid=%0b required 1 0",
                   r, bus.o_core_start, bus.o_res_valid);
        end
      end else begin
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL bp_frame_done: fd=%0b busy=%0b required 1 0", frame_done, busy);
        end
      end
    end
    tick(); tick();
    checks++;
    if (n_results - br != 4 || rx_log[br+1] !== 8'd1 || riter_log[br+1] !== eit) begin
      errors++;
      $display("FAIL bp_results: count=%0d x1=%0d iter1=%0d required 4 1 %0d",
               n_results - br, rx_log[br+1], riter_log[br+1], eit);
    end
    bus.i_res_ready = 1'b1;
  endtask

  task automatic test_zero_size();
    int bs = n_starts, br = n_results;
    bit busy_seen = 1'b0;
    start_frame(16'h1234, 16'h5678, 16'h0001, 16'h0001, 8'd0, 8'd3);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: fd=%0b busy=%0b required 1 0", frame_done, busy);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: fd=%0b required 0", frame_done);
    end
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0) busy_seen = 1'b1;
      tick();
    end
    checks++;
    if (busy_seen || n_starts != bs || n_results != br) begin
      errors++;
      $display("FAIL zero_quiet: busy_seen=%0b starts=%0d results=%0d required 0 0 0",
               busy_seen, n_starts - bs, n_results - br);
    end
  endtask

  task automatic test_abort();
    int bs = n_starts, br = n_results, bf = n_fd;
    int n = 0;
    core_lat = 3;
    bus.i_res_ready = 1'b1;
    start_frame(16'h0100, 16'h0200, 16'h0010, 16'h0020, 8'd4, 8'd1);
    // Find the ISSUE cycle of pixel (1,0).
    while (!(bus.o_core_start && n_starts - bs == 1) && n < 50) begin tick(); n++; end
    checks++;
    if (bus.o_core_start !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach: pixel 1 never issued");
    end
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.o_res_valid !== 1'b0 || bus.o_core_start !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%0b valid=%0b start=%0b required 0 0 0",
               busy, bus.o_res_valid, bus.o_core_start);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (n_starts - bs != 2 || n_results - br != 1 || n_fd != bf || bus.o_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_late_done: starts=%0d results=%0d fd=%0d valid=%0b required 2 1 0 0",
               n_starts - bs, n_results - br, n_fd - bf, bus.o_res_valid);
    end
    // Start and abort together in IDLE: abort wins.
    i_abort = 1'b1;
    start_frame(16'h0100, 16'h0200, 16'h0010, 16'h0020, 8'd4, 8'd1);
    i_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.o_core_start !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_clash: busy=%0b start=%0b required 0 0", busy, bus.o_core_start);
    end
    tick();
    // A fresh frame after the abort runs from (0,0).
    bs = n_starts; br = n_results; bf = n_fd;
    start_frame(16'h2000, 16'h0300, 16'h0010, 16'h0040, 8'd2, 8'd1);
    wait_idle(100, "abort_restart_idle");
    tick(); tick();
    checks++;
    if (n_starts - bs != 2 || cr_log[bs] !== 16'h2000 || cr_log[bs+1] !== 16'h2010 ||
        ci_log[bs] !== 16'h0300) begin
      errors++;
      $display("FAIL abort_restart_coord: starts=%0d cr0=%h cr1=%h ci0=%h required 2 2000 2010 0300",
               n_starts - bs, cr_log[bs], cr_log[bs+1], ci_log[bs]);
    end
    checks++;
    if (n_results - br != 2 || rx_log[br] !== 8'd0 || rx_log[br+1] !== 8'd1 ||
        ry_log[br] !== 8'd0 || n_fd - bf != 1) begin
      errors++;
      $display("FAIL abort_restart_res: results=%0d x0=%0d x1=%0d y0=%0d fd=%0d required 2 0 1 0 1",
               n_results - br, rx_log[br], rx_log[br+1], ry_log[br], n_fd - bf);
    end
  endtask

  task automatic test_wrap_busy_start();
    int bs = n_starts, br = n_results, bf = n_fd;
    int n = 0;
    logic [W-1:0] exp_cr [3];
    exp_cr[0] = 16'h7F00; exp_cr[1] = 16'h8000; exp_cr[2] = 16'h8100;
    core_lat = 1;
    bus.i_res_ready = 1'b1;
    start_frame(16'h7F00, 16'h0123, 16'h0100, 16'h0040, 8'd3, 8'd1);
    while (n_starts - bs < 1 && n < 50) begin tick(); n++; end
    // Try to restart with a different config while busy.
    start_frame(16'h0000, 16'h0000, 16'h0001, 16'h0001, 8'd5, 8'd5);
    wait_idle(100, "wrap_idle");
    tick(); tick();
    checks++;
    if (n_starts - bs != 3 || n_results - br != 3 || n_fd - bf != 1) begin
      errors++;
      $display("FAIL wrap_counts: starts=%0d results=%0d fd=%0d required 3 3 1",
               n_starts - bs, n_results - br, n_fd - bf);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cr_log[bs+i] !== exp_cr[i] || ci_log[bs+i] !== 16'h0123 ||
          rx_log[br+i] !== DIM_W'(i)) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: cr=%h ci=%h x=%0d required %h 0123 %0d",
                 i, cr_log[bs+i], ci_log[bs+i], rx_log[br+i], exp_cr[i], i);
      end
    end
  endtask

  task automatic test_reset_in_emit();
    int br, bf;
    int n = 0;
    core_lat = 2;
    bus.i_res_ready = 1'b1;
    br = n_results; bf = n_fd;
    start_frame(16'h4000, 16'h0500, 16'h0100, 16'h0010, 8'd2, 8'd1);
    // Let pixel 0 through, then stall on pixel (1,0) and reset in EMIT.
    while (!(bus.o_res_valid && bus.o_res_x == 8'd1) && n < 60) begin tick(); n++; end
    bus.i_res_ready = 1'b0;
    checks++;
    if (bus.o_res_valid !== 1'b1 || bus.o_core_cr !== 16'h4100) begin
      errors++;
      $display("FAIL rst_emit_reach: valid=%0b cr=%h required 1 4100", bus.o_res_valid, bus.o_core_cr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, frame_done, bus.o_core_start, bus.o_res_valid, bus.o_res_unbounded} !== 5'b0 ||
        {bus.o_core_cr, bus.o_core_ci, bus.o_res_x, bus.o_res_y, bus.o_res_iter} !== '0) begin
      errors++;
      $display("FAIL rst_emit_outputs: busy=%0b valid=%0b cr=%h ci=%h x=%0d iter=%0d required all 0",
               busy, bus.o_res_valid, bus.o_core_cr, bus.o_core_ci, bus.o_res_x, bus.o_res_iter);
    end
    rst = 1'b0;
    bus.i_res_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (n_results - br != 1 || n_fd != bf || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit_dropped: results=%0d fd=%0d busy=%0b required 1 0 0",
               n_results - br, n_fd - bf, busy);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    cr0 = '0; ci0 = '0; cr_step = '0; ci_step = '0; cols = '0; rows = '0;
    bus.i_res_ready = 1'b0;
    test_reset();
    test_frame_2x2();
    test_backpressure();
    test_zero_size();
    test_abort();
    test_wrap_busy_start();
    test_reset_in_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
